// File: rtl/rf_copy_engine.sv
// Block copy / block fill engine that masters the single-port register file.
// Copy moves one word per RD -> CAP -> WR triplet; fill writes one word per cycle.
module rf_copy_engine #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [AW-1:0]    src_addr,
  input  logic [AW-1:0]    dst_addr,
  input  logic [AW:0]      len,
  input  logic [WIDTH-1:0] fill_data,
  output logic             busy,
  output logic             done,
  output logic [AW:0]      words_done,
  output logic             rf_rden,
  output logic             rf_wren,
  output logic [AW-1:0]    rf_address,
  output logic [WIDTH-1:0] rf_wrdata,
  input  logic [WIDTH-1:0] rf_rddata
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_CAP  = 3'd2,
    S_WR   = 3'd3,
    S_DONE = 3'd4
  } state_t;

  localparam logic [AW:0] MAX_LEN  = (AW+1)'(DEPTH);
  localparam logic [AW:0] ZERO_LEN = (AW+1)'(0);
  localparam logic [AW:0] ONE_LEN  = (AW+1)'(1);

  state_t           state_r;
  state_t           state_nxt_s;
  logic             mode_r;
  logic [AW-1:0]    src_r;
  logic [AW-1:0]    dst_r;
  logic [AW:0]      len_r;
  logic [AW:0]      cnt_r;
  logic [WIDTH-1:0] fill_r;
  logic [WIDTH-1:0] data_r;
  logic [AW:0]      len_clamp_s;
  logic [AW:0]      cnt_inc_s;
  logic             rf_rden_s;
  logic             rf_wren_s;
  logic [AW-1:0]    rf_address_s;
  logic [WIDTH-1:0] rf_wrdata_s;

  assign len_clamp_s = (len > MAX_LEN) ? MAX_LEN : len;
  assign cnt_inc_s   = cnt_r + ONE_LEN;

  // Next-state decode; cnt_inc_s is the word count once the current write lands
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (start) begin
          if (len_clamp_s == ZERO_LEN) begin
            state_nxt_s = S_DONE;
          end else if (mode) begin
            state_nxt_s = S_WR;
          end else begin
            state_nxt_s = S_RD;
          end
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_RD:  state_nxt_s = S_CAP;
      S_CAP: state_nxt_s = S_WR;
      S_WR: begin
        if (cnt_inc_s == len_r) begin
          state_nxt_s = S_DONE;
        end else if (mode_r) begin
          state_nxt_s = S_WR;
        end else begin
          state_nxt_s = S_RD;
        end
      end
      S_DONE:  state_nxt_s = S_IDLE;
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // Bus outputs decoded purely from state and latched command registers
  always_comb begin
    rf_rden_s    = 1'b0;
    rf_wren_s    = 1'b0;
    rf_address_s = {AW{1'b0}};
    rf_wrdata_s  = {WIDTH{1'b0}};
    case (state_r)
      S_RD: begin
        rf_rden_s    = 1'b1;
        rf_address_s = src_r + cnt_r[AW-1:0];
      end
      S_WR: begin
        rf_wren_s    = 1'b1;
        rf_address_s = dst_r + cnt_r[AW-1:0];
        rf_wrdata_s  = mode_r ? fill_r : data_r;
      end
      default: begin
        rf_rden_s = 1'b0;
      end
    endcase
  end

  assign rf_rden    = rf_rden_s;
  assign rf_wren    = rf_wren_s;
  assign rf_address = rf_address_s;
  assign rf_wrdata  = rf_wrdata_s;
  assign busy       = (state_r != S_IDLE);
  assign done       = (state_r == S_DONE);
  assign words_done = cnt_r;

  // State, command latch, read-data capture and word counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= S_IDLE;
      mode_r  <= 1'b0;
      src_r   <= {AW{1'b0}};
      dst_r   <= {AW{1'b0}};
      len_r   <= ZERO_LEN;
      cnt_r   <= ZERO_LEN;
      fill_r  <= {WIDTH{1'b0}};
      data_r  <= {WIDTH{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      case (state_r)
        S_IDLE: begin
          if (start) begin
            mode_r <= mode;
            src_r  <= src_addr;
            dst_r  <= dst_addr;
            len_r  <= len_clamp_s;
            fill_r <= fill_data;
            cnt_r  <= ZERO_LEN;
          end
        end
        S_CAP:   data_r <= rf_rddata;
        S_WR:    cnt_r  <= cnt_inc_s;
        default: ;
      endcase
    end
  end

endmodule

// File: doc/rf_copy_engine.md
Name: rf_copy_engine

Overview:
- Bus master that drives the single-port 8 x 16 register file read/write interface.
- Performs block copy (src -> dst) or block fill (constant -> dst) over the register file under a start/busy/done command handshake.
- Sits between the control path and the register file; it is the only agent issuing rden/wren while busy.

Parameters:
WIDTH, 16, data width; matches register file word width
DEPTH, 8, register file depth; address width AW = $clog2(DEPTH) (localparam, 3 by default)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous active-low reset
start  input  1  command strobe, sampled only in IDLE
mode  input  1  0 = copy, 1 = fill; sampled with start
src_addr  input  AW  first source address (copy mode)
dst_addr  input  AW  first destination address
len  input  AW+1  word count, 0..DEPTH
fill_data  input  WIDTH  fill value (fill mode); sampled with start
busy  output  1  high from the cycle after accepted start until the end of DONE
done  output  1  one-cycle pulse in DONE state
words_done  output  AW+1  count of words written for the current or last command
rf_rden  output  1  register file read enable
rf_wren  output  1  register file write enable
rf_address  output  AW  register file address
rf_wrdata  output  WIDTH  register file write data
rf_rddata  input  WIDTH  register file read data, valid the cycle after rf_rden

Behaviour:
- Reset (rst=0, async): state IDLE; busy, done, rf_rden, rf_wren = 0; rf_address, rf_wrdata, words_done, internal counters/data = 0.
- All outputs are decoded from registered state and registers only; no combinational path from any input to any output.
- States: IDLE, RD, CAP, WR, DONE.
- IDLE: if start=1, latch mode, src, dst, len, fill_data; clear words_done.
  - len=0 -> DONE.
  - mode=0 -> RD.
  - mode=1 -> WR.
  - start=0 -> stay in IDLE.
- RD (copy): rf_rden=1, rf_address=src+i; next state CAP.
- CAP: no enables asserted. The register file updated rf_rddata at the end of RD; capture rf_rddata into data_q at the end of CAP; next state WR.
- WR: rf_wren=1, rf_address=dst+i, rf_wrdata=data_q (copy) or latched fill_data (fill). At the end of WR: i++, words_done++.
  - i==len -> DONE.
  - Otherwise, copy -> RD, fill -> WR.
- DONE: done=1 for exactly one cycle; next state IDLE. busy=1 in RD, CAP, WR, DONE; busy=0 in IDLE.
- Latency, start sampled at edge E0:
  - Copy of N words: done high during cycle 3N+1 after E0.
  - Fill of N words: done high during cycle N+1 after E0.
  - len=0: done high during cycle 1 after E0, with no rf accesses.
- rf_rden and rf_wren are never high in the same cycle (the register file treats both high as no-op).
- Addresses are AW-bit and wrap modulo DEPTH (e.g. src=6, len=4 reads 6,7,0,1).
- len > DEPTH is clamped to DEPTH.
- Overlapping copy regions are processed in ascending order, word by word (read i, then write i). Result is defined by that order; no overlap correction.
- start while busy is ignored; command inputs are don't-care outside IDLE.
- Reset asserted mid-command: immediate return to IDLE, enables drop asynchronously, no further accesses. Register file contents reflect only the writes completed before reset.
- words_done holds its final value in IDLE until the next accepted start.

Test Plan:
1. Reset, then preload RF[0..3]=0x1111,0x2222,0x3333,0x4444; copy src=0, dst=4, len=4 -> RF[4..7] match the source values; done pulses 13 cycles after the start edge; words_done=4; rden/wren never high together.
2. Fill mode, dst=2, len=3, fill_data=0xA5A5 -> RF[2..4]=0xA5A5 with wren on 3 consecutive cycles; done in cycle 4; other words unchanged.
3. Wrap: copy src=6, dst=1, len=3 with RF[6]=0x0006, RF[7]=0x0007, RF[0]=0x0000 -> RF[1..3]=0x0006,0x0007,0x0000; address sequence RD6,WR1,RD7,WR2,RD0,WR3.
4. len=0 -> no rden/wren; done pulses the cycle after start; words_done=0. Also a second start while busy -> ignored, only one done pulse.
5. Overlap: RF[0..2]=1,2,3; copy src=0, dst=1, len=2 -> RF[1]=1, RF[2]=1 (ascending order).
6. Assert rst during the 2nd WR of a 4-word fill -> outputs 0 immediately, state IDLE, only the 1st word written; a subsequent command runs normally.
